// File: rtl/edge_pkg.sv
// edge_pkg: shared mode encoding, width helpers and default image geometry for the edge filter
package edge_pkg;
    typedef enum logic [2:0] {
        MODE_BYPASS = 3'b000,
        MODE_SOBEL  = 3'b001,
        MODE_HORZ   = 3'b010,
        MODE_VERT   = 3'b011,
        MODE_THRESH = 3'b100
    } mode_e;
    localparam int DEF_WIDTH    = 320;
    localparam int DEF_HEIGHT   = 240;
    localparam int DEF_CH_BITS  = 4;
    localparam int DEF_CHANNELS = 3;
    function automatic int grad_w(input int ch_bits);
        return ch_bits + 4;
    endfunction
    function automatic int mag_w(input int ch_bits);
        return ch_bits + 3;
    endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: column-addressed two-row delay line returning the pixels one and two rows above
module line_buffer
    import edge_pkg::*;
#(
    parameter int DEPTH = DEF_WIDTH,
    parameter int WIDTH = DEF_CH_BITS * DEF_CHANNELS
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         tap1,
    output logic [WIDTH-1:0]         tap2
);
    logic [WIDTH-1:0] row1 [DEPTH];
    logic [WIDTH-1:0] row2 [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            row1[addr] <= din;
            row2[addr] <= row1[addr];
            tap1       <= row1[addr];
            tap2       <= row2[addr];
        end
    end
endmodule

// File: rtl/edge_filter_stream.sv
// edge_filter_stream: two-stage streaming per-channel Sobel edge filter with frame-latched mode
module edge_filter_stream
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_WIDTH,
    parameter int IMG_HEIGHT = DEF_HEIGHT,
    parameter int CH_BITS    = DEF_CH_BITS,
    parameter int CHANNELS   = DEF_CHANNELS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic                          startofpacket_in,
    input  logic                          endofpacket_in,
    input  logic [CH_BITS*CHANNELS-1:0]   data_in,
    output logic                          ready_out,
    input  logic                          ready_in,
    output logic                          valid_out,
    output logic                          startofpacket_out,
    output logic                          endofpacket_out,
    output logic [CH_BITS*CHANNELS-1:0]   data_out,
    input  logic [2:0]                    freq_flag,
    input  logic [CH_BITS+2:0]            thresh
);
    localparam int DATA_W = CH_BITS * CHANNELS;
    localparam int GW = grad_w(CH_BITS);
    localparam int MW = mag_w(CH_BITS);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic en, accept;
    logic [CW-1:0] col_q, cur_col;
    logic [RW-1:0] row_q, cur_row;
    logic [2:0] mode_q, cur_mode;
    assign en = ready_in;
    assign accept = valid_in & ready_in;
    assign ready_out = ready_in;
    assign cur_col = startofpacket_in ? '0 : col_q;
    assign cur_row = startofpacket_in ? '0 : row_q;
    assign cur_mode = startofpacket_in ? freq_flag : mode_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= MODE_BYPASS;
        end else if (accept) begin
            mode_q <= cur_mode;
            col_q  <= (endofpacket_in || cur_col == COL_LAST) ? '0 : cur_col + CW'(1);
            row_q  <= endofpacket_in ? '0 : (cur_col != COL_LAST) ? cur_row :
                      (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end
    end

    logic [DATA_W-1:0] t1, t2;
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W)) u_lb (
        .clk  (clk),
        .en   (accept),
        .addr (cur_col),
        .din  (data_in),
        .tap1 (t1),
        .tap2 (t2)
    );

    logic v1, sop1, eop1, mask1;
    logic [2:0] m1;
    logic [DATA_W-1:0] d1;
    always_ff @(posedge clk) begin
        if (reset) v1 <= 1'b0;
        else if (en) v1 <= accept;
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            sop1  <= startofpacket_in;
            eop1  <= endofpacket_in;
            d1    <= data_in;
            m1    <= cur_mode;
            mask1 <= cur_row < RW'(2) || cur_col < CW'(2);
        end
    end

    // Window columns only shift on real beats, so bubbles never corrupt the neighbourhood
    logic [3*DATA_W-1:0] w1, w2;
    always_ff @(posedge clk) begin
        if (en && v1) begin
            w1 <= {t2, t1, d1};
            w2 <= w1;
        end
    end

    logic [DATA_W-1:0] edge_px;
    logic [CHANNELS-1:0] hit;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CH_BITS-1:0] a0, a1, a2, b0, b2, c0, c1, c2;
        logic [CH_BITS+1:0] sl, sr, st, sb;
        logic signed [GW-1:0] gx, gy;
        logic [MW-1:0] ax, ay, mag, sel, sh;
        assign a0 = w2[2*DATA_W + i*CH_BITS +: CH_BITS];
        assign a1 = w1[2*DATA_W + i*CH_BITS +: CH_BITS];
        assign a2 = t2[i*CH_BITS +: CH_BITS];
        assign b0 = w2[DATA_W + i*CH_BITS +: CH_BITS];
        assign b2 = t1[i*CH_BITS +: CH_BITS];
        assign c0 = w2[i*CH_BITS +: CH_BITS];
        assign c1 = w1[i*CH_BITS +: CH_BITS];
        assign c2 = d1[i*CH_BITS +: CH_BITS];
        assign sl = {2'b0, a0} + {1'b0, b0, 1'b0} + {2'b0, c0};
        assign sr = {2'b0, a2} + {1'b0, b2, 1'b0} + {2'b0, c2};
        assign st = {2'b0, a0} + {1'b0, a1, 1'b0} + {2'b0, a2};
        assign sb = {2'b0, c0} + {1'b0, c1, 1'b0} + {2'b0, c2};
        assign gx = $signed({2'b0, sr}) - $signed({2'b0, sl});
        assign gy = $signed({2'b0, sb}) - $signed({2'b0, st});
        assign ax = gx[GW-1] ? MW'(-gx) : MW'(gx);
        assign ay = gy[GW-1] ? MW'(-gy) : MW'(gy);
        assign mag = ax + ay;
        assign sel = (m1 == MODE_HORZ) ? ay : (m1 == MODE_VERT) ? ax : mag;
        assign sh = sel >> 2;
        assign edge_px[i*CH_BITS +: CH_BITS] = |sh[MW-1:CH_BITS] ? '1 : sh[CH_BITS-1:0];
        assign hit[i] = mag >= thresh;
    end

    logic [DATA_W-1:0] filt, res;
    assign filt = (m1 == MODE_THRESH) ? {DATA_W{|hit}} : edge_px;
    assign res = (m1 == MODE_BYPASS || m1 > MODE_THRESH) ? d1 : mask1 ? '0 : filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out         <= 1'b0;
            startofpacket_out <= 1'b0;
            endofpacket_out   <= 1'b0;
            data_out          <= '0;
        end else if (en) begin
            valid_out         <= v1;
            startofpacket_out <= v1 & sop1;
            endofpacket_out   <= v1 & eop1;
            data_out          <= res;
        end
    end
endmodule

// File: tb/tb_edge_filter_stream.sv
// tb_edge_filter_stream: scoreboard bench for the edge filter on a reduced 16x12 frame
module tb_edge_filter_stream;
    localparam int W = 16;
    localparam int H = 12;
    localparam int N = W * H;

    logic clk = 0;
    logic reset, valid_in, sop_in, eop_in, ready_in, ready_out;
    logic valid_out, sop_out, eop_out;
    logic [11:0] data_in, data_out;
    logic [2:0] freq_flag;
    logic [6:0] thresh;

    edge_filter_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CH_BITS(4), .CHANNELS(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .valid_in          (valid_in),
        .startofpacket_in  (sop_in),
        .endofpacket_in    (eop_in),
        .data_in           (data_in),
        .ready_out         (ready_out),
        .ready_in          (ready_in),
        .valid_out         (valid_out),
        .startofpacket_out (sop_out),
        .endofpacket_out   (eop_out),
        .data_out          (data_out),
        .freq_flag         (freq_flag),
        .thresh            (thresh)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int en_cnt = 0;
    int mq = 0;
    logic [13:0] q[$];
    int tq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] pix(input int pat, input int r, input int c);
        if (pat == 0) return 12'h555;
        if (pat == 1) return (r % 5 == 0) ? 12'hFFF : 12'h000;
        return 12'(((r * 37 + c * 11 + r * c * 5) * 73) ^ (c << 7));
    endfunction

    function automatic int p(input int pat, input int r, input int c, input int ch);
        logic [11:0] x;
        x = pix(pat, r, c);
        return int'((x >> (4 * ch)) & 12'hF);
    endfunction

    function automatic logic [11:0] model(input int m, input int pat, input int r, input int c,
                                          input logic [11:0] d);
        int gx, gy, ax, ay, v;
        logic hit;
        logic [11:0] o;
        if (m < 1 || m > 4) return d;
        if (r < 2 || c < 2) return 12'h000;
        o = '0;
        hit = 0;
        for (int ch = 0; ch < 3; ch++) begin
            gx = p(pat, r-2, c, ch) + 2*p(pat, r-1, c, ch) + p(pat, r, c, ch)
               - p(pat, r-2, c-2, ch) - 2*p(pat, r-1, c-2, ch) - p(pat, r, c-2, ch);
            gy = p(pat, r, c-2, ch) + 2*p(pat, r, c-1, ch) + p(pat, r, c, ch)
               - p(pat, r-2, c-2, ch) - 2*p(pat, r-2, c-1, ch) - p(pat, r-2, c, ch);
            ax = gx < 0 ? -gx : gx;
            ay = gy < 0 ? -gy : gy;
            v = (m == 2) ? ay : (m == 3) ? ax : ax + ay;
            v = v / 4;
            if (v > 15) v = 15;
            o[ch*4 +: 4] = 4'(v);
            if (ax + ay >= int'(thresh)) hit = 1;
        end
        return (m == 4) ? (hit ? 12'hFFF : 12'h000) : o;
    endfunction

    always @(posedge clk) if (ready_in) en_cnt <= en_cnt + 1;

    logic prev_rdy = 1'b1;
    logic [14:0] prev_out;
    logic [13:0] exp_b;
    int exp_t;
    always @(negedge clk) begin
        if (reset) prev_rdy <= 1'b1;
        else begin
            chk("ready_out", ready_out, ready_in);
            if (!prev_rdy) chk("hold", {valid_out, sop_out, eop_out, data_out}, prev_out);
            if (valid_out && ready_in) begin
                if (q.size() == 0) chk("extra_beat", valid_out, 1'b0);
                else begin
                    exp_b = q.pop_front();
                    exp_t = tq.pop_front();
                    chk("beat", {sop_out, eop_out, data_out}, exp_b);
                    chk("latency", en_cnt, exp_t + 2);
                end
            end
            prev_rdy <= ready_in;
            prev_out <= {valid_out, sop_out, eop_out, data_out};
        end
    end

    task automatic send(input logic [11:0] d, input logic s, input logic e, input int pat,
                        input int r, input int c, input int stall);
        logic acc;
        if (stall != 0 && $urandom_range(0, 9) == 0) begin
            valid_in = 0;
            ready_in = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        valid_in = 1; data_in = d; sop_in = s; eop_in = e;
        acc = 0;
        while (!acc) begin
            ready_in = (stall != 0 && $urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
            acc = ready_in;
            if (acc) begin
                if (s) mq = int'(freq_flag);
                q.push_back({s, e, model(mq, pat, r, c, d)});
                tq.push_back(en_cnt);
            end
            @(posedge clk); #1;
        end
        valid_in = 0; sop_in = 0; eop_in = 0;
    endtask

    task automatic frame(input int pat, input logic [2:0] ff0, input logic [2:0] ff1,
                         input int chg, input int stall, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            freq_flag = (chg >= 0 && b >= chg) ? ff1 : ff0;
            send(pix(pat, b / W, b % W), b == 0, b == N - 1, pat, b / W, b % W, stall);
        end
    endtask

    task automatic drain();
        valid_in = 0;
        ready_in = 1;
        for (int i = 0; i < 20 && q.size() != 0; i++) begin @(posedge clk); #1; end
        repeat (3) begin @(posedge clk); #1; end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1; valid_in = 0; sop_in = 0; eop_in = 0; ready_in = 1;
        data_in = '0; freq_flag = 3'd0; thresh = 7'd30;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {valid_out, sop_out, eop_out, data_out}, 0);
        reset = 0;
        frame(0, 3'd1, 3'd1, -1, 0, N); drain();
        frame(0, 3'd0, 3'd0, -1, 0, N); drain();
        frame(1, 3'd1, 3'd1, -1, 0, N); drain();
        frame(1, 3'd3, 3'd3, -1, 0, N); drain();
        frame(1, 3'd4, 3'd4, -1, 0, N); drain();
        thresh = 7'd20;
        for (int m = 1; m <= 7; m++) begin
            frame(2, 3'(m), 3'(m), -1, 0, N);
        end
        drain();
        thresh = 7'd30;
        frame(1, 3'd1, 3'd1, -1, 1, N); drain();
        frame(1, 3'd4, 3'd4, -1, 1, N); drain();
        frame(2, 3'd0, 3'd1, 50, 0, N);
        frame(2, 3'd1, 3'd1, -1, 0, N); drain();
        freq_flag = 3'd1;
        send(12'hABC, 1, 1, 2, 0, 0, 0);
        frame(2, 3'd2, 3'd2, -1, 0, N); drain();
        frame(1, 3'd1, 3'd1, -1, 0, 100);
        reset = 1; valid_in = 0; ready_in = 1;
        @(posedge clk); #1;
        q.delete(); tq.delete(); mq = 0;
        reset = 0;
        chk("post_reset", {valid_out, sop_out, eop_out, data_out}, 0);
        freq_flag = 3'd1;
        for (int k = 0; k < 3; k++) send(pix(2, 0, k), 0, 0, 2, 0, k, 0);
        frame(1, 3'd1, 3'd1, -1, 1, N); drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
